countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, sets the clock cycles per timer tick; legal range is 2 or more.
REQ-002 clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces every register to its reset value immediately, independent of clk.
REQ-004 load  input  1  single-cycle strobe: copy start_value into count and clear the prescaler.
REQ-005 start_value  input  8  reload value, sampled only when load=1.
REQ-006 start  input  1  single-cycle strobe: begin or resume the countdown.
REQ-007 stop  input  1  single-cycle strobe: pause the countdown.
REQ-008 count  output  8  current remaining seconds, registered.
REQ-009 running  output  1  high only in state RUN, registered.
REQ-010 done  output  1  high only in state DONE, registered.
REQ-011 expired  output  1  one-cycle pulse on the clock edge that enters DONE, registered.

Function
REQ-012 The block SHALL implement four states: IDLE, RUN, PAUSE and DONE.
REQ-013 Prescaler width SHALL be ceil(log2(CLK_HZ)) bits.
- In RUN, the prescaler counts 0..CLK_HZ-1.
- A tick occurs on the cycle where prescaler=CLK_HZ-1; on that cycle the prescaler returns to 0.
- One tick therefore occurs every exactly CLK_HZ cycles.
REQ-014 On a tick in RUN, the block SHALL decrement count by 1.
- If count was 1, count goes to 0, the state goes to DONE and expired pulses.
REQ-015 The prescaler SHALL hold its value in IDLE, PAUSE and DONE.
- It is cleared only by load, by reset, or by entering DONE.
REQ-016 Input priority within a cycle SHALL be load > stop > start > tick.
REQ-017 In IDLE:
- load: count <= start_value, prescaler <= 0, stay in IDLE.
- start with count != 0: go to RUN.
- start with count = 0: go to DONE and pulse expired.
REQ-018 In RUN:
- load: count <= start_value, prescaler <= 0, stay in RUN; a load value of 0 goes to DONE and pulses expired.
- stop: go to PAUSE, with count and prescaler frozen and no tick applied that cycle.
- start: ignored.
REQ-019 In PAUSE:
- start: go to RUN, resuming from the frozen prescaler value.
- load: count <= start_value, prescaler <= 0, stay in PAUSE.
- stop: ignored.
REQ-020 In DONE:
- count holds 0.
- start and stop are ignored.
- load: count <= start_value, prescaler <= 0, go to IDLE.
REQ-021 count SHALL never wrap: 0 is never decremented, and 8'hFF loads and counts down normally.
REQ-022 expired SHALL be high for exactly one cycle per entry into DONE.
REQ-023 Simultaneous start and stop SHALL behave as stop in RUN, and as start in IDLE and PAUSE.
REQ-024 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-025 While reset=1, the block SHALL hold:
- state = IDLE
- count = 0
- prescaler = 0
- running = 0, done = 0, expired = 0
REQ-026 Reset asserted mid-count SHALL abort the countdown immediately, with no expired pulse.
REQ-027 After reset is released, the block SHALL stay in IDLE until load or start.

Verification (CLK_HZ=4)
REQ-028 Basic countdown:
- Stimulus: load with start_value=3, then start.
- Response: running rises 1 cycle after start; count steps 3 -> 2 -> 1 -> 0 at 4-cycle intervals.
- expired pulses exactly once, coincident with count=0, done=1 and running=0.
REQ-029 Pause and resume:
- Stimulus: load 5, start, stop on prescaler=2, wait 10 cycles, start.
- Response: count frozen at its value and running=0 during the pause.
- The next decrement occurs 2 cycles after resume.
REQ-030 Zero start:
- Stimulus: after reset, start with no prior load.
- Response: DONE reached in 1 cycle with count=0 and one expired pulse.
- A following start leaves done=1, with no further pulse.
REQ-031 Priority:
- Stimulus: in RUN with count=9, assert load (start_value=7) together with stop.
- Response: count=7, state RUN, prescaler 0.
- Stimulus: in RUN, assert stop on a tick cycle.
- Response: no decrement.
REQ-032 Full range:
- Stimulus: load 8'hFF and run to completion.
- Response: 255 decrements in exactly 1020 cycles after start, with no wrap.
- Stimulus: load 0 while in DONE.
- Response: IDLE with count=0.
REQ-033 Asynchronous reset:
- Stimulus: assert reset between clock edges while count=4 in RUN.
- Response: outputs clear before the next clk edge, with no expired pulse.

Source files
------------

// File: rtl/countdown_timer.sv
// Countdown timer: 8-bit seconds counter decremented once per CLK_HZ cycles.
// Controlled by load/start/stop strobes; all outputs are registered.
module countdown_timer #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] start_value,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] count,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_count;
  logic [7:0]    w_count_nxt;
  logic [PW-1:0] r_psc;
  logic [PW-1:0] w_psc_nxt;
  logic          r_running;
  logic          r_done;
  logic          r_expired;
  logic          w_tick;
  logic          w_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= 8'd0;
      r_psc     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_psc     <= w_psc_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
      r_expired <= w_expire;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_psc_nxt   = r_psc;
    w_tick      = (r_psc == TICK_AT);
    unique case (r_state)
      S_IDLE: begin
        if (load) begin
          w_count_nxt = start_value;
          w_psc_nxt   = '0;
        end else if (start) begin
          if (r_count == 8'd0) begin
            w_state_nxt = S_DONE;
            w_psc_nxt   = '0;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (load) begin
          w_count_nxt = start_value;
          w_psc_nxt   = '0;
          if (start_value == 8'd0) begin
            w_state_nxt = S_DONE;
          end
        end else if (stop) begin
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          w_psc_nxt = '0;
          // Count of 0 is never decremented, so no wrap is possible.
          if (r_count <= 8'd1) begin
            w_count_nxt = 8'd0;
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_count - 8'd1;
          end
        end else begin
          w_psc_nxt = r_psc + 1'b1;
        end
      end
      S_PAUSE: begin
        if (load) begin
          w_count_nxt = start_value;
          w_psc_nxt   = '0;
        end else if (start) begin
          if (r_count == 8'd0) begin
            w_state_nxt = S_DONE;
            w_psc_nxt   = '0;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_DONE: begin
        if (load) begin
          w_count_nxt = start_value;
          w_psc_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_expire = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  end

  assign count   = r_count;
  assign running = r_running;
  assign done    = r_done;
  assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer at CLK_HZ=4: directed scenarios
// plus random strobes compared against a cycle-level behavioural model.
module tb_countdown_timer;

  localparam int HZ = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] start_value = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       expired;

  int checks = 0;
  int failures = 0;

  int m_mode;
  int m_cnt;
  int m_phase;
  bit m_exp;

  countdown_timer #(.CLK_HZ(HZ)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .start_value(start_value),
    .start(start),
    .stop(stop),
    .count(count),
    .running(running),
    .done(done),
    .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cnt = 0;
    m_phase = 0;
    m_exp = 1'b0;
  endtask

  task automatic model_step(input bit ld, input int sv,
                            input bit st, input bit sp);
    m_exp = 1'b0;
    if (ld) begin
      m_cnt = sv;
      m_phase = 0;
      if (m_mode == M_DONE) m_mode = M_IDLE;
      else if (m_mode == M_RUN && sv == 0) begin
        m_mode = M_DONE;
        m_exp = 1'b1;
      end
    end else if (sp && m_mode == M_RUN) begin
      m_mode = M_PAUSE;
    end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSE)) begin
      if (m_cnt == 0) begin
        m_mode = M_DONE;
        m_exp = 1'b1;
        m_phase = 0;
      end else begin
        m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == HZ) begin
        m_phase = 0;
        m_cnt--;
        if (m_cnt == 0) begin
          m_mode = M_DONE;
          m_exp = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input bit ld, input logic [7:0] sv,
                     input bit st, input bit sp);
    @(negedge clk);
    load = ld;
    start_value = sv;
    start = st;
    stop = sp;
    @(posedge clk);
    model_step(ld, int'(sv), st, sp);
    #1;
    load = 1'b0;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 8'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got cnt=%0d run=%b done=%b exp=%b want 0/0/0/0",
               count, running, done, expired);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'd0, 0, 0);
      checks++;
      if (count !== 8'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_hold: got cnt=%0d run=%b done=%b exp=%b",
                 count, running, done, expired);
      end
    end
  endtask

  task automatic test_basic();
    int npulse;
    do_reset();
    cyc(1, 8'd3, 0, 0);
    cyc(0, 8'd0, 1, 0);
    checks++;
    if (running !== 1'b1 || count !== 8'd3) begin
      failures++;
      $display("FAIL basic_start: got run=%b cnt=%0d want 1/3", running, count);
    end
    npulse = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc(0, 8'd0, 0, 0);
      if (expired === 1'b1) npulse++;
      checks++;
      if (k <= 12 && count !== 8'(3 - k / 4)) begin
        failures++;
        $display("FAIL basic_count: k=%0d got %0d want %0d", k, count, 3 - k / 4);
      end
      checks++;
      if (expired !== (k == 12) || done !== (k >= 12) || running !== (k < 12)) begin
        failures++;
        $display("FAIL basic_flags: k=%0d got exp=%b done=%b run=%b", k, expired, done, running);
      end
    end
    checks++;
    if (npulse != 1) begin
      failures++;
      $display("FAIL basic_pulses: got %0d want 1", npulse);
    end
  endtask

  task automatic test_zero_start();
    do_reset();
    cyc(0, 8'd0, 1, 0);
    checks++;
    if (done !== 1'b1 || expired !== 1'b1 || count !== 8'd0 || running !== 1'b0) begin
      failures++;
      $display("FAIL zero_start: got done=%b exp=%b cnt=%0d run=%b want 1/1/0/0",
               done, expired, count, running);
    end
    cyc(0, 8'd0, 1, 0);
    checks++;
    if (done !== 1'b1 || expired !== 1'b0) begin
      failures++;
      $display("FAIL zero_restart: got done=%b exp=%b want 1/0", done, expired);
    end
    cyc(0, 8'd0, 0, 1);
    checks++;
    if (done !== 1'b1 || expired !== 1'b0 || count !== 8'd0) begin
      failures++;
      $display("FAIL done_stop: got done=%b exp=%b cnt=%0d", done, expired, count);
    end
  endtask

  task automatic test_pause();
    int f;
    int guard;
    do_reset();
    cyc(1, 8'd5, 0, 0);
    cyc(0, 8'd0, 1, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);
    guard = 0;
    while (m_phase != 2 && guard < 10) begin
      cyc(0, 8'd0, 0, 0);
      guard++;
    end
    cyc(0, 8'd0, 0, 1);
    f = m_cnt;
    checks++;
    if (running !== 1'b0 || count !== 8'(f) || f != 4) begin
      failures++;
      $display("FAIL pause_enter: got run=%b cnt=%0d want 0/%0d (model %0d)",
               running, count, 4, f);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 8'd0, 0, (i == 5));
      checks++;
      if (running !== 1'b0 || count !== 8'(f) || done !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold: i=%0d got run=%b cnt=%0d want 0/%0d",
                 i, running, count, f);
      end
    end
    cyc(0, 8'd0, 1, 0);
    checks++;
    if (running !== 1'b1 || count !== 8'(f)) begin
      failures++;
      $display("FAIL pause_resume: got run=%b cnt=%0d want 1/%0d", running, count, f);
    end
    cyc(0, 8'd0, 0, 0);
    checks++;
    if (count !== 8'(f)) begin
      failures++;
      $display("FAIL resume_early: got %0d want %0d", count, f);
    end
    cyc(0, 8'd0, 0, 0);
    checks++;
    if (count !== 8'(f - 1)) begin
      failures++;
      $display("FAIL resume_tick: got %0d want %0d", count, f - 1);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(1, 8'd9, 0, 0);
    cyc(0, 8'd0, 1, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(1, 8'd7, 0, 1);
    checks++;
    if (count !== 8'd7 || running !== 1'b1) begin
      failures++;
      $display("FAIL prio_load_stop: got cnt=%0d run=%b want 7/1", count, running);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 8'd0, 0, 0);
      checks++;
      if (count !== ((i == 4) ? 8'd6 : 8'd7)) begin
        failures++;
        $display("FAIL prio_psc_clear: i=%0d got %0d want %0d",
                 i, count, (i == 4) ? 6 : 7);
      end
    end
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 1, 1);
    checks++;
    if (count !== 8'd6 || running !== 1'b0) begin
      failures++;
      $display("FAIL prio_stop_tick: got cnt=%0d run=%b want 6/0", count, running);
    end
  endtask

  task automatic test_full_range();
    int k;
    int ndec;
    logic [7:0] prev;
    do_reset();
    cyc(1, 8'hFF, 0, 0);
    cyc(0, 8'd0, 1, 0);
    k = 0;
    ndec = 0;
    prev = count;
    while (done !== 1'b1 && k < 1100) begin
      cyc(0, 8'd0, 0, 0);
      k++;
      if (count == prev - 8'd1) ndec++;
      else if (count !== prev) begin
        checks++;
        failures++;
        $display("FAIL full_step: k=%0d got %0d after %0d", k, count, prev);
      end
      prev = count;
    end
    checks++;
    if (k != 1020 || ndec != 255 || count !== 8'd0) begin
      failures++;
      $display("FAIL full_range: got cycles=%0d decs=%0d cnt=%0d want 1020/255/0",
               k, ndec, count);
    end
    cyc(0, 8'd0, 0, 0);
    checks++;
    if (count !== 8'd0 || done !== 1'b1 || expired !== 1'b0) begin
      failures++;
      $display("FAIL full_nowrap: got cnt=%0d done=%b exp=%b", count, done, expired);
    end
    cyc(1, 8'd0, 0, 0);
    checks++;
    if (count !== 8'd0 || done !== 1'b0 || running !== 1'b0 || expired !== 1'b0) begin
      failures++;
      $display("FAIL done_load0: got cnt=%0d done=%b run=%b exp=%b want 0/0/0/0",
               count, done, running, expired);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 8'd4, 0, 0);
    cyc(0, 8'd0, 1, 0);
    cyc(0, 8'd0, 0, 0);
    checks++;
    if (count !== 8'd4 || running !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: got cnt=%0d run=%b want 4/1", count, running);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (count !== 8'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin
      failures++;
      $display("FAIL areset_async: got cnt=%0d run=%b done=%b exp=%b want 0/0/0/0",
               count, running, done, expired);
    end
    @(posedge clk);
    #1;
    checks++;
    if (count !== 8'd0 || running !== 1'b0 || expired !== 1'b0) begin
      failures++;
      $display("FAIL areset_hold: got cnt=%0d run=%b exp=%b", count, running, expired);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 8'd0, 0, 0);
      checks++;
      if (count !== 8'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin
        failures++;
        $display("FAIL areset_after: i=%0d cnt=%0d run=%b done=%b exp=%b",
                 i, count, running, done, expired);
      end
    end
  endtask

  task automatic test_random();
    bit ld;
    bit st;
    bit sp;
    logic [7:0] sv;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 9) == 0);
      sv = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, 6));
      cyc(ld, sv, st, sp);
      checks++;
      if (count !== 8'(m_cnt) || running !== (m_mode == M_RUN) ||
          done !== (m_mode == M_DONE) || expired !== m_exp) begin
        failures++;
        $display("FAIL random: i=%0d got cnt=%0d run=%b done=%b exp=%b want %0d/%b/%b/%b",
                 i, count, running, done, expired, m_cnt,
                 (m_mode == M_RUN), (m_mode == M_DONE), m_exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_zero_start();
    test_pause();
    test_priority();
    test_full_range();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
